// File: rtl/mem_access.sv
// Memory-access pipeline stage: word-aligned req/ack bus transactions, read-modify-write for sub-word stores,
// and load alignment/extension. Optional misaligned-access trap is enabled with MEM_MISALIGN_TRAP_EN.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_w_reg_enable_i,
    input  logic              mem_w_reg_enable_i,
    input  logic [4:0]        w_reg_addr_i,
    input  logic [DATA_W-1:0] ex_w_reg_data_i,
    input  logic              r_mem_enable_i,
    input  logic [ADDR_W-1:0] r_mem_addr_i,
    input  logic              w_mem_enable_i,
    input  logic [ADDR_W-1:0] w_mem_addr_i,
    input  logic [DATA_W-1:0] w_mem_data_i,
    input  logic [2:0]        data_type_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              stall_o,
    output logic              w_reg_enable_o,
    output logic [4:0]        w_reg_addr_o,
    output logic [DATA_W-1:0] w_reg_data_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_B    = 3'd1;
    localparam logic [2:0] T_H    = 3'd2;
    localparam logic [2:0] T_W    = 3'd3;
    localparam logic [2:0] T_BU   = 3'd4;
    localparam logic [2:0] T_HU   = 3'd5;

    logic [1:0]        state_r;
    logic [2:0]        type_r;
    logic              is_store_r;
    logic              wb_en_r;
    logic [4:0]        rd_r;
    logic [1:0]        r_lane_r;
    logic [ADDR_W-1:0] w_addr_r;
    logic [DATA_W-1:0] sdata_r;
    logic              ack_armed_r;
    logic              ack_s;
    logic              mis_s;

    function automatic logic [DATA_W-1:0] extract_load(input logic [2:0] dtype, input logic [1:0] lane,
                                                       input logic [DATA_W-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (dtype)
            T_B:     r = {{24{b[7]}}, b};
            T_BU:    r = {24'h000000, b};
            T_H:     r = {{16{h[15]}}, h};
            T_HU:    r = {16'h0000, h};
            T_W:     r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/halfword lane of the old word with the store data.
    function automatic logic [DATA_W-1:0] merge_store(input logic [2:0] dtype, input logic [1:0] lane,
                                                      input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] r;
        r = old_word;
        case (dtype)
            T_B, T_BU: r[{lane, 3'b000} +: 8]    = data[7:0];
            T_H, T_HU: r[{lane[1], 4'b0000} +: 16] = data[15:0];
            default:   r = data;
        endcase
        return r;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    logic [ADDR_W-1:0] acc_addr_s;

    function automatic logic is_misaligned(input logic [2:0] dtype, input logic [1:0] lane);
        logic r;
        case (dtype)
            T_H, T_HU: r = lane[0];
            T_W:       r = (lane != 2'b00);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Faulting address: stores are checked on the write address, loads on the read address.
    always_comb begin
        acc_addr_s = r_mem_addr_i;
        if (w_mem_enable_i) begin
            acc_addr_s = w_mem_addr_i;
        end else begin
            acc_addr_s = r_mem_addr_i;
        end
        mis_s = is_misaligned(data_type_i, acc_addr_s[1:0]);
    end

    // Trap report, visible only during the RESP cycle of a misaligned access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else if (state_r == S_IDLE && r_mem_enable_i && mis_s) begin
            misalign_o      <= 1'b1;
            misalign_addr_o <= acc_addr_s;
        end else if (state_r == S_RESP) begin
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o      <= misalign_o;
            misalign_addr_o <= misalign_addr_o;
        end
    end
`else
    // Without the trap, low address bits are simply ignored.
    always_comb begin
        mis_s = 1'b0;
    end
`endif

    // An ack in the first cycle of a request is not a legal completion.
    always_comb begin
        ack_s = bus_ack_i & ack_armed_r;
    end

    // Stall upstream from the accepting IDLE cycle until the response cycle.
    always_comb begin
        stall_o = 1'b0;
        case (state_r)
            S_IDLE:  stall_o = r_mem_enable_i & ~rst;
            S_READ:  stall_o = ~rst;
            S_WRITE: stall_o = ~rst;
            S_RESP:  stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

    // Main control FSM and registered bus / write-back outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            type_r         <= T_NONE;
            is_store_r     <= 1'b0;
            wb_en_r        <= 1'b0;
            rd_r           <= 5'd0;
            r_lane_r       <= 2'b00;
            w_addr_r       <= '0;
            sdata_r        <= '0;
            ack_armed_r    <= 1'b0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= '0;
            bus_wdata_o    <= '0;
            w_reg_enable_o <= 1'b0;
            w_reg_addr_o   <= 5'd0;
            w_reg_data_o   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ack_armed_r <= 1'b0;
                    if (r_mem_enable_i) begin
                        type_r         <= data_type_i;
                        is_store_r     <= w_mem_enable_i;
                        wb_en_r        <= mem_w_reg_enable_i;
                        rd_r           <= w_reg_addr_i;
                        r_lane_r       <= r_mem_addr_i[1:0];
                        w_addr_r       <= w_mem_addr_i;
                        sdata_r        <= w_mem_data_i;
                        w_reg_enable_o <= 1'b0;
                        if (data_type_i == T_NONE || mis_s) begin
                            state_r <= S_RESP;
                        end else if (w_mem_enable_i && data_type_i == T_W) begin
                            state_r     <= S_WRITE;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= 1'b1;
                            bus_addr_o  <= {w_mem_addr_i[ADDR_W-1:2], 2'b00};
                            bus_wdata_o <= w_mem_data_i;
                        end else begin
                            state_r    <= S_READ;
                            bus_req_o  <= 1'b1;
                            bus_we_o   <= 1'b0;
                            bus_addr_o <= {r_mem_addr_i[ADDR_W-1:2], 2'b00};
                        end
                    end else begin
                        w_reg_enable_o <= ex_w_reg_enable_i && (w_reg_addr_i != 5'd0);
                        w_reg_addr_o   <= w_reg_addr_i;
                        w_reg_data_o   <= ex_w_reg_data_i;
                    end
                end
                S_READ: begin
                    ack_armed_r <= 1'b1;
                    if (ack_s && is_store_r) begin
                        // Request stays high: the merged write follows directly.
                        state_r     <= S_WRITE;
                        ack_armed_r <= 1'b0;
                        bus_we_o    <= 1'b1;
                        bus_addr_o  <= {w_addr_r[ADDR_W-1:2], 2'b00};
                        bus_wdata_o <= merge_store(type_r, w_addr_r[1:0], bus_rdata_i, sdata_r);
                    end else if (ack_s) begin
                        state_r        <= S_RESP;
                        ack_armed_r    <= 1'b0;
                        bus_req_o      <= 1'b0;
                        w_reg_enable_o <= wb_en_r;
                        w_reg_addr_o   <= rd_r;
                        w_reg_data_o   <= extract_load(type_r, r_lane_r, bus_rdata_i);
                    end else begin
                        state_r <= S_READ;
                    end
                end
                S_WRITE: begin
                    ack_armed_r <= 1'b1;
                    if (ack_s) begin
                        state_r     <= S_RESP;
                        ack_armed_r <= 1'b0;
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                    end else begin
                        state_r <= S_WRITE;
                    end
                end
                S_RESP: begin
                    state_r        <= S_IDLE;
                    ack_armed_r    <= 1'b0;
                    w_reg_enable_o <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    ack_armed_r <= 1'b0;
                    bus_req_o   <= 1'b0;
                    bus_we_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: transaction-level model of bus and write-back traffic plus directed literals.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_w_reg_enable, mem_w_reg_enable, r_mem_enable, w_mem_enable;
    logic [4:0]  w_reg_addr;
    logic [31:0] ex_w_reg_data, r_mem_addr, w_mem_addr, w_mem_data;
    logic [2:0]  data_type;
    logic        bus_req_o, bus_we_o, bus_ack, stall_o, w_reg_enable_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata, w_reg_data_o;
    logic [4:0]  w_reg_addr_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
`endif

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_w_reg_enable_i(ex_w_reg_enable), .mem_w_reg_enable_i(mem_w_reg_enable),
        .w_reg_addr_i(w_reg_addr), .ex_w_reg_data_i(ex_w_reg_data),
        .r_mem_enable_i(r_mem_enable), .r_mem_addr_i(r_mem_addr),
        .w_mem_enable_i(w_mem_enable), .w_mem_addr_i(w_mem_addr), .w_mem_data_i(w_mem_data),
        .data_type_i(data_type),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
        .stall_o(stall_o), .w_reg_enable_o(w_reg_enable_o), .w_reg_addr_o(w_reg_addr_o),
        .w_reg_data_o(w_reg_data_o)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    bus_t        exp_bus[$];
    wb_t         exp_wb[$];
    logic [31:0] mem [logic [31:0]];
    int          ack_lat = 3;
    int          inject_req = 0;
    logic [31:0] last_wdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_load(input int dt, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int sh;
        v = 32'h0;
        if (dt == 1 || dt == 4) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'hFF;
            if (dt == 1 && v >= 32'd128) v = v - 32'd256;
        end else if (dt == 2 || dt == 5) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'hFFFF;
            if (dt == 2 && v >= 32'd32768) v = v - 32'd65536;
        end else if (dt == 3) begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input int dt, input logic [31:0] a, input logic [31:0] old,
                                                input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (dt == 2 || dt == 5) begin
            mask = 32'hFFFF; sh = 16 * int'(a[1]);
        end else begin
            mask = 32'hFF;   sh = 8 * int'(a[1:0]);
        end
        return (old & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    function automatic logic model_misaligned(input int dt, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (dt == 2 || dt == 5) return a[0];
        if (dt == 3) return a[1:0] != 2'b00;
`endif
        return 1'b0;
    endfunction

    // Bus slave: acks after ack_lat request cycles, with memory behind it.
    initial begin
        int cnt = 0;
        int seen = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_ack) begin
                bus_ack = 1'b0;
                cnt = (bus_req_o && !rst) ? 1 : 0;
            end else if (inject_req != seen) begin
                seen = inject_req;
                bus_ack = 1'b1;
            end else if (bus_req_o && !rst) begin
                cnt++;
                if (cnt >= ack_lat) begin
                    bus_ack = 1'b1;
                    if (bus_we_o) begin
                        mem[bus_addr_o] = bus_wdata_o;
                        last_wdata = bus_wdata_o;
                    end else begin
                        bus_rdata = rd_mem(bus_addr_o);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Per-cycle comparison of bus transactions and write-backs against the model queues.
    initial begin
        logic prev_req;
        bus_t cur, e;
        wb_t  w;
        prev_req = 1'b0;
        cur = '{1'b0, 32'h0, 32'h0};
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus_req_o && (!prev_req || bus_ack)) begin
                    if (exp_bus.size() == 0) begin
                        chk("unexpected_bus_txn", bus_addr_o, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_bus.pop_front();
                        chk("bus_we", bus_we_o, e.we);
                        chk("bus_addr", bus_addr_o, e.addr);
                        if (e.we) chk("bus_wdata", bus_wdata_o, e.wdata);
                    end
                    cur = '{bus_we_o, bus_addr_o, bus_wdata_o};
                end else if (bus_req_o) begin
                    chk("bus_stable_we", bus_we_o, cur.we);
                    chk("bus_stable_addr", bus_addr_o, cur.addr);
                    if (cur.we) chk("bus_stable_wdata", bus_wdata_o, cur.wdata);
                end else begin
                    cur = cur;
                end
                if (w_reg_enable_o) begin
                    if (exp_wb.size() == 0) begin
                        chk("unexpected_wb", {27'h0, w_reg_addr_o}, 32'hFFFF_FFFF);
                    end else begin
                        w = exp_wb.pop_front();
                        chk("wb_addr", {27'h0, w_reg_addr_o}, {27'h0, w.rd});
                        chk("wb_data", w_reg_data_o, w.data);
                    end
                end
                prev_req = bus_req_o;
            end
        end
    end

    task automatic clear_inputs();
        r_mem_enable = 1'b0; w_mem_enable = 1'b0; mem_w_reg_enable = 1'b0; ex_w_reg_enable = 1'b0;
        data_type = 3'd0;
    endtask

    task automatic ex_op(input logic [4:0] rd, input logic [31:0] d, input logic en);
        @(negedge clk);
        clear_inputs();
        ex_w_reg_enable = en; w_reg_addr = rd; ex_w_reg_data = d;
        if (en && rd != 5'd0) exp_wb.push_back('{rd, d});
        @(posedge clk);
        #1;
        chk("ex_wb_en", {31'h0, w_reg_enable_o}, {31'h0, (en && rd != 5'd0)});
        if (en && rd != 5'd0) chk("ex_wb_data", w_reg_data_o, d);
        @(negedge clk);
        clear_inputs();
    endtask

    // Issue one memory operation, hold it while stalled, then check the RESP cycle.
    task automatic mem_op(input string name, input int dt, input logic st, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rd, input int exp_stall,
                          input logic use_lit, input logic [31:0] lit);
        logic [31:0] word, old;
        logic        mis, wb;
        int          n;
        word = {a[31:2], 2'b00};
        old  = rd_mem(word);
        mis  = model_misaligned(dt, a);
        wb   = !st && dt != 0 && !mis;
        if (dt != 0 && !mis) begin
            if (st && dt == 3) begin
                exp_bus.push_back('{1'b1, word, sd});
            end else begin
                exp_bus.push_back('{1'b0, word, 32'h0});
                if (st) exp_bus.push_back('{1'b1, word, model_merge(dt, a, old, sd)});
                else    exp_wb.push_back('{rd, model_load(dt, a, old)});
            end
        end
        @(negedge clk);
        r_mem_enable = 1'b1; r_mem_addr = a; w_mem_enable = st; w_mem_addr = a; w_mem_data = sd;
        data_type = dt[2:0]; mem_w_reg_enable = !st; w_reg_addr = rd;
        ex_w_reg_enable = 1'b1; ex_w_reg_data = 32'hE0E0_E0E0;
        #1;
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 100) chk({name, "_timeout"}, 32'd1, 32'd0);
        chk({name, "_stall"}, n, exp_stall);
        chk({name, "_wb_en"}, {31'h0, w_reg_enable_o}, {31'h0, wb});
        if (use_lit) chk({name, "_lit"}, w_reg_data_o, lit);
`ifdef MEM_MISALIGN_TRAP_EN
        chk({name, "_misalign"}, {31'h0, misalign_o}, {31'h0, mis});
        if (mis) chk({name, "_misalign_addr"}, misalign_addr_o, a);
`endif
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        w_reg_addr = 5'd0; ex_w_reg_data = 32'h0; r_mem_addr = 32'h0; w_mem_addr = 32'h0; w_mem_data = 32'h0;
        #22;
        chk("reset_req", {31'h0, bus_req_o}, 32'd0);
        chk("reset_stall", {31'h0, stall_o}, 32'd0);
        chk("reset_wb_en", {31'h0, w_reg_enable_o}, 32'd0);
        chk("reset_bus_addr", bus_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word load with 3-cycle bus latency.
        mem[32'h100] = 32'hDEADBEEF;
        ack_lat = 3;
        mem_op("lw", 3, 1'b0, 32'h100, 32'h0, 5'd5, 4, 1'b1, 32'hDEADBEEF);

        // Sub-word loads with sign/zero extension.
        ack_lat = 2;
        mem[32'h100] = 32'h80FF0000;
        mem_op("lb_103",  1, 1'b0, 32'h103, 32'h0, 5'd6, 3, 1'b1, 32'hFFFFFF80);
        mem_op("lbu_103", 4, 1'b0, 32'h103, 32'h0, 5'd7, 3, 1'b1, 32'h00000080);
        mem_op("lh_102",  2, 1'b0, 32'h102, 32'h0, 5'd8, 3, 1'b1, 32'hFFFF80FF);
        mem_op("lhu_102", 5, 1'b0, 32'h102, 32'h0, 5'd9, 3, 1'b1, 32'h000080FF);
        mem_op("lb_102",  1, 1'b0, 32'h102, 32'h0, 5'd10, 3, 1'b1, 32'hFFFFFFFF);
        mem_op("lbu_100", 4, 1'b0, 32'h100, 32'h0, 5'd11, 3, 1'b1, 32'h00000000);

        // Sub-word stores via read-modify-write, then a readback through the DUT.
        mem[32'h100] = 32'h11223344;
        mem_op("sb_101", 1, 1'b1, 32'h101, 32'h000000AB, 5'd12, 5, 1'b0, 32'h0);
        chk("sb_101_merged", last_wdata, 32'h1122AB44);
        mem_op("sh_102", 2, 1'b1, 32'h102, 32'h1234BEEF, 5'd13, 5, 1'b0, 32'h0);
        chk("sh_102_merged", last_wdata, 32'hBEEFAB44);
        mem_op("lw_back", 3, 1'b0, 32'h100, 32'h0, 5'd14, 3, 1'b1, 32'hBEEFAB44);

        // Word store: single write transaction, no read.
        mem_op("sw_200", 3, 1'b1, 32'h200, 32'hCAFEF00D, 5'd15, 3, 1'b0, 32'h0);
        chk("sw_200_wdata", last_wdata, 32'hCAFEF00D);

        // Execute-result write-back path, including x0 and disabled requests.
        ex_op(5'd3, 32'h12345678, 1'b1);
        ex_op(5'd0, 32'h0000FFFF, 1'b1);
        ex_op(5'd9, 32'h0000A5A5, 1'b0);
        ex_op(5'd31, 32'h87654321, 1'b1);

        // Request with no data type: no bus access, no write-back.
        mem_op("type_none", 0, 1'b0, 32'h100, 32'h0, 5'd4, 1, 1'b0, 32'h0);

        // Misaligned accesses: trapped when enabled, otherwise low bits ignored.
`ifdef MEM_MISALIGN_TRAP_EN
        mem_op("lw_102", 3, 1'b0, 32'h102, 32'h0, 5'd16, 1, 1'b0, 32'h0);
        mem_op("lh_101", 2, 1'b0, 32'h101, 32'h0, 5'd17, 1, 1'b0, 32'h0);
`else
        mem_op("lw_102", 3, 1'b0, 32'h102, 32'h0, 5'd16, 3, 1'b1, 32'hBEEFAB44);
        mem_op("lh_101", 2, 1'b0, 32'h101, 32'h0, 5'd17, 3, 1'b1, 32'hFFFFAB44);
`endif

        // Reset in the middle of a read, followed by a stray ack.
        ack_lat = 6;
        mem[32'h300] = 32'h55AA55AA;
        exp_bus.push_back('{1'b0, 32'h300, 32'h0});
        @(negedge clk);
        r_mem_enable = 1'b1; r_mem_addr = 32'h300; data_type = 3'd3; mem_w_reg_enable = 1'b1; w_reg_addr = 5'd7;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_pre_req", {31'h0, bus_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_req", {31'h0, bus_req_o}, 32'd0);
        chk("rst_we", {31'h0, bus_we_o}, 32'd0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'd0);
        chk("rst_wb_en", {31'h0, w_reg_enable_o}, 32'd0);
        chk("rst_wb_addr", {27'h0, w_reg_addr_o}, 32'd0);
        chk("rst_wb_data", w_reg_data_o, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rst_misalign", {31'h0, misalign_o}, 32'd0);
`endif
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        inject_req++;
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_req", {31'h0, bus_req_o}, 32'd0);
        chk("post_rst_stall", {31'h0, stall_o}, 32'd0);
        chk("post_rst_wb_en", {31'h0, w_reg_enable_o}, 32'd0);

        ack_lat = 2;
        mem_op("lw_after_rst", 3, 1'b0, 32'h300, 32'h0, 5'd18, 3, 1'b1, 32'h55AA55AA);
        repeat (3) @(negedge clk);
        chk("bus_queue_empty", exp_bus.size(), 32'd0);
        chk("wb_queue_empty", exp_wb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
